// File: rtl/imem_loader.sv
// Boot-time program loader for the core's instruction memory.
// Takes a valid/ready byte stream, builds little-endian 32-bit words and writes
// them to consecutive word-aligned IMEM addresses. The core's PC is held in reset
// until the requested number of words has been written. The loader then reports
// a wrapping 32-bit checksum of the image.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [31:0]       imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    // Largest legal word_count. It needs the extra top bit of word_count.
    localparam logic [ADDR_W:0] Capacity = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] OneWord  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      byte_idx_q;
    logic [23:0]     asm_q;
    logic [31:0]     wdata_q;
    logic [31:0]     addr_q;
    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] words_q;
    logic [ADDR_W:0] words_inc;
    logic [31:0]     checksum_q;
    logic            hold_q;
    logic            err_q;

    logic            count_legal;
    logic            start_ok;
    logic            start_bad;
    logic            byte_fire;
    logic            last_byte;
    logic            last_word;

    // Decode handshakes, start legality and the end-of-word/end-of-load conditions.
    always_comb begin
        count_legal = (word_count != '0) && (word_count <= Capacity);
        start_ok    = (state_q == StIdle) && start && count_legal;
        start_bad   = (state_q == StIdle) && start && !count_legal;
        byte_fire   = (state_q == StRecv) && byte_valid;
        last_byte   = byte_fire && (byte_idx_q == 2'd3);
        words_inc   = words_q + OneWord;
        last_word   = (words_inc == count_q);
    end

    // Next-state logic and the state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StRecv;
                end
            end
            StRecv: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (last_byte) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                state_d = last_word ? StDone : StRecv;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Byte index and the assembly of the first three bytes of the current word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx_q <= 2'd0;
            asm_q      <= 24'h0;
        end else if (start_ok) begin
            byte_idx_q <= 2'd0;
        end else if (byte_fire) begin
            // The index wraps to 0 after the fourth byte, so it is ready for the next word.
            byte_idx_q <= byte_idx_q + 2'd1;
            unique case (byte_idx_q)
                2'd0:    asm_q[7:0]   <= byte_data;
                2'd1:    asm_q[15:8]  <= byte_data;
                2'd2:    asm_q[23:16] <= byte_data;
                default: asm_q        <= asm_q;
            endcase
        end
    end

    // Write data changes only on the RECV->WRITE transition. The fourth byte goes into the MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdata_q <= 32'h0;
        end else if (last_byte) begin
            wdata_q <= {byte_data, asm_q};
        end
    end

    // Address, latched count and progress counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            words_q <= '0;
        end else if (start_ok) begin
            addr_q  <= BASE_ADDR;
            count_q <= word_count;
            words_q <= '0;
        end else if (state_q == StWrite) begin
            addr_q  <= addr_q + 32'd4;
            words_q <= words_inc;
        end
    end

    // Running checksum. It is cleared on an accepted start and keeps its value after DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= 32'h0;
        end else if (start_ok) begin
            checksum_q <= 32'h0;
        end else if (state_q == StWrite) begin
            checksum_q <= checksum_q + wdata_q;
        end
    end

    // Core hold. It starts asserted and is released on the DONE->IDLE edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= 1'b1;
        end else if (start_ok) begin
            hold_q <= 1'b1;
        end else if (state_q == StDone) begin
            hold_q <= 1'b0;
        end
    end

    // Error pulse for a start that carries an illegal word_count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= start_bad;
        end
    end

    assign imem_waddr = addr_q;
    assign imem_wdata = wdata_q;
    assign checksum   = checksum_q;
    assign cpu_hold   = hold_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=3, BASE_ADDR=0).
// Loads are described in a vector table. The IMEM writes they should produce are
// queued in a scoreboard and checked as the writes occur.
module tb_imem_loader;

    localparam int unsigned AW   = 3;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW:0]   word_count;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [31:0]   imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   checksum;

    imem_loader #(
        .ADDR_W    (AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    typedef struct packed {
        logic [3:0]   wc;
        logic [1:0]   stall;
        logic [255:0] words;
        logic [31:0]  sum;
    } vec_t;

    vec_t        vecs [5];
    logic [63:0] sb [$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          we_cnt   = 0;
    logic [31:0] done_sum = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor and done tracker, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            logic [63:0] e;
            we_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h with no write expected",
                         imem_waddr, imem_wdata);
            end else begin
                e = sb.pop_front();
                chk("write_addr", imem_waddr, e[63:32]);
                chk("write_data", imem_wdata, e[31:0]);
            end
        end
        if (reset && done) begin
            done_cnt++;
            done_sum = checksum;
        end
    end

    task automatic do_start(input logic [AW:0] wc);
        start      = 1'b1;
        word_count = wc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        logic r;
        bit   ok;
        ok         = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            r = byte_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int  s;
        int  d0;
        int  lat;
        bit  ok;
        d0 = done_cnt;
        for (int w = 0; w < int'(v.wc); w++) begin
            sb.push_back({BASE + 32'(4 * w), v.words[32*w +: 32]});
        end
        do_start(v.wc);
        s = cyc;
        chk({name, "_ready_after_start"}, {31'd0, byte_ready}, 32'd1);
        chk({name, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        chk({name, "_hold_during_load"}, {31'd0, cpu_hold}, 32'd1);
        for (int w = 0; w < int'(v.wc); w++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(v.words[32*w + 8*k +: 8], int'(v.stall));
            end
        end
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!cpu_hold) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_hold_release_timeout"}, 32'd0, 32'd1);
        lat = cyc - s + 1;
        if (v.stall == 2'd0) chk({name, "_latency"}, 32'(lat), 32'(5 * int'(v.wc) + 2));
        chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_checksum_at_done"}, done_sum, v.sum);
        chk({name, "_checksum_idle"}, checksum, v.sum);
        chk({name, "_all_writes_seen"}, 32'(sb.size()), 32'd0);
        chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic illegal(input logic [AW:0] wc, input logic exp_hold, input logic [31:0] exp_sum);
        int w0;
        w0 = we_cnt;
        do_start(wc);
        @(negedge clk);
        chk("illegal_err_pulse", {31'd0, err}, 32'd1);
        chk("illegal_stays_idle", {30'd0, byte_ready, busy}, 32'd0);
        chk("illegal_hold", {31'd0, cpu_hold}, {31'd0, exp_hold});
        @(negedge clk);
        chk("illegal_err_one_cycle", {31'd0, err}, 32'd0);
        chk("illegal_checksum", checksum, exp_sum);
        repeat (6) @(negedge clk);
        chk("illegal_no_write", 32'(we_cnt - w0), 32'd0);
        chk("illegal_still_idle", {30'd0, byte_ready, busy}, 32'd0);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_hold"}, {31'd0, cpu_hold}, 32'd1);
        chk({name, "_strobes"}, {27'd0, byte_ready, imem_we, busy, done, err}, 32'd0);
        chk({name, "_checksum"}, checksum, 32'd0);
        chk({name, "_waddr"}, imem_waddr, BASE);
        chk({name, "_wdata"}, imem_wdata, 32'd0);
    endtask

    initial begin
        int   changes;
        logic [31:0] mid_words [4];

        vecs[0] = '{wc: 4'd1, stall: 2'd0, words: 256'h13, sum: 32'h0000_0013};
        vecs[1] = '{wc: 4'd3, stall: 2'd2,
                    words: {160'd0, 32'hFFFF_FFFF, 32'h2, 32'h1}, sum: 32'h0000_0002};
        vecs[2] = '{wc: 4'd8, stall: 2'd0,
                    words: {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0},
                    sum: 32'd28};
        vecs[3] = '{wc: 4'd2, stall: 2'd1,
                    words: {192'd0, 32'h1234_5678, 32'hDEAD_BEEF}, sum: 32'hF0E2_1567};
        vecs[4] = '{wc: 4'd1, stall: 2'd0, words: 256'h55, sum: 32'h0000_0055};
        mid_words[0] = 32'hA1B2_C3D4;
        mid_words[1] = 32'h0102_0304;
        mid_words[2] = 32'h5566_7788;
        mid_words[3] = 32'h99AA_BBCC;

        reset      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Reset, then stay idle for 20 cycles.
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");
        changes = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpu_hold !== 1'b1 || byte_ready !== 1'b0 || imem_we !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || err !== 1'b0 || checksum !== 32'd0) changes++;
        end
        chk("idle_stable", 32'(changes), 32'd0);
        chk("idle_no_write", 32'(we_cnt), 32'd0);

        // Illegal counts, both before any load has run.
        @(posedge clk);
        #1;
        illegal(4'd0, 1'b1, 32'd0);
        illegal(4'd9, 1'b1, 32'd0);

        // Table-driven loads.
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // An illegal start after a load leaves the released hold and the checksum alone.
        @(posedge clk);
        #1;
        illegal(4'd0, 1'b0, vecs[3].sum);

        // A 4-word load with a stray start in RECV, then reset after two words.
        @(posedge clk);
        #1;
        for (int w = 0; w < 4; w++) sb.push_back({BASE + 32'(4 * w), mid_words[w]});
        do_start(4'd4);
        send_byte(mid_words[0][7:0], 0);
        start      = 1'b1;
        word_count = 4'd1;
        send_byte(mid_words[0][15:8], 0);
        start = 1'b0;
        send_byte(mid_words[0][23:16], 0);
        send_byte(mid_words[0][31:24], 0);
        for (int k = 0; k < 4; k++) send_byte(mid_words[1][8*k +: 8], 0);
        // The state is now WRITE for word 1. Let that write occur before the reset.
        @(posedge clk);
        #1;
        chk("midload_checksum_before_reset", checksum, mid_words[0] + mid_words[1]);
        chk("midload_still_held", {31'd0, cpu_hold}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_vals("midload_reset");
        chk("midload_two_writes", 32'(sb.size()), 32'd2);
        sb.delete();
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        run_vec(vecs[4], "fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
